// File: rtl/tdm_demux_16ch.sv
// Registered 1-to-16 time-division demultiplexer: frame-sequenced or
// address-selected routing of a shared word bus into 16 channel registers.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for a frame marker (or in address mode)
// RUN   | mid-frame, ch_idx holds the next channel
module tdm_demux_16ch #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  frame_start,
  input  logic                  addr_mode,
  input  logic [3:0]            in_sel,
  output logic [16*DATA_W-1:0]  out_data,
  output logic [15:0]           out_valid,
  output logic [3:0]            ch_idx,
  output logic                  frame_done,
  output logic                  frame_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q,      state_d;
  logic [3:0]           ch_idx_q,     ch_idx_d;
  logic [16*DATA_W-1:0] data_q,       data_d;
  logic [15:0]          out_valid_q,  out_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_err_q,  frame_err_d;

  logic                 wr_en;
  logic [3:0]           wr_ch;

  always_comb begin
    state_d      = state_q;
    ch_idx_d     = ch_idx_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    wr_en        = 1'b0;
    wr_ch        = 4'd0;

    if (in_valid) begin
      if (addr_mode) begin
        wr_en    = 1'b1;
        wr_ch    = in_sel;
        state_d  = IDLE;
        ch_idx_d = 4'd0;
      end else if (frame_start) begin
        // A marker inside a running frame truncates it and restarts at channel 0.
        frame_err_d = (state_q == RUN);
        wr_en       = 1'b1;
        wr_ch       = 4'd0;
        ch_idx_d    = 4'd1;
        state_d     = RUN;
      end else if (state_q == IDLE) begin
        frame_err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        wr_ch = ch_idx_q;
        if (ch_idx_q == 4'd15) begin
          frame_done_d = 1'b1;
          ch_idx_d     = 4'd0;
          state_d      = IDLE;
        end else begin
          ch_idx_d = ch_idx_q + 4'd1;
        end
      end
    end

    data_d      = data_q;
    out_valid_d = 16'd0;
    if (wr_en) begin
      data_d[int'(wr_ch)*DATA_W +: DATA_W] = in_data;
      out_valid_d                          = 16'd1 << wr_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_idx_q     <= 4'd0;
      data_q       <= '0;
      out_valid_q  <= 16'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_idx_q     <= ch_idx_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = out_valid_q;
  assign ch_idx     = ch_idx_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_16ch.sv
// Directed and randomized checks of tdm_demux_16ch against a frame-position
// reference model (channel array plus "open frame" position).
module tb_tdm_demux_16ch;
  localparam int DATA_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DATA_W-1:0]     in_data = '0;
  logic                  frame_start = 1'b0;
  logic                  addr_mode = 1'b0;
  logic [3:0]            in_sel = '0;
  logic [16*DATA_W-1:0]  out_data;
  logic [15:0]           out_valid;
  logic [3:0]            ch_idx;
  logic                  frame_done;
  logic                  frame_err;

  tdm_demux_16ch #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .frame_start(frame_start), .addr_mode(addr_mode), .in_sel(in_sel),
    .out_data(out_data), .out_valid(out_valid), .ch_idx(ch_idx),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: channel contents and position in the open frame (-1 = none).
  logic [DATA_W-1:0] mem [16];
  int                pos;
  logic [15:0]       m_strobe;
  logic              m_done, m_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*DATA_W-1:0] model_flat();
    logic [16*DATA_W-1:0] f;
    for (int k = 0; k < 16; k++) f[k*DATA_W +: DATA_W] = mem[k];
    return f;
  endfunction

  task automatic model_edge();
    m_strobe = 16'd0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) mem[k] = '0;
      pos = -1;
    end else if (in_valid) begin
      if (addr_mode) begin
        mem[in_sel] = in_data;
        m_strobe[in_sel] = 1'b1;
        pos = -1;
      end else if (frame_start) begin
        m_err = (pos >= 0);
        mem[0] = in_data;
        m_strobe[0] = 1'b1;
        pos = 1;
      end else if (pos < 0) begin
        m_err = 1'b1;
      end else begin
        mem[pos] = in_data;
        m_strobe[pos] = 1'b1;
        if (pos == 15) begin
          m_done = 1'b1;
          pos = -1;
        end else begin
          pos++;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic fs, input logic am,
                      input logic [3:0] sel, input logic [DATA_W-1:0] d);
    int exp_idx;
    in_valid = v; frame_start = fs; addr_mode = am; in_sel = sel; in_data = d;
    @(posedge clk);
    model_edge();
    #1;
    exp_idx = (pos < 0) ? 0 : pos;
    chk("out_data",   128'(out_data),   128'(model_flat()));
    chk("out_valid",  128'(out_valid),  128'(m_strobe));
    chk("ch_idx",     128'(ch_idx),     128'(exp_idx));
    chk("frame_done", 128'(frame_done), 128'(m_done));
    chk("frame_err",  128'(frame_err),  128'(m_err));
  endtask

  function automatic logic [DATA_W-1:0] chan(input int k);
    return out_data[k*DATA_W +: DATA_W];
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = '0;
    pos = -1;

    // Reset
    rst_n = 1'b0;
    step(1, 1, 0, 0, 8'hEE);
    step(0, 0, 0, 0, 8'h00);
    chk("reset_out_data", 128'(out_data), 128'(0));
    rst_n = 1'b1;

    // Full frame
    for (int k = 0; k < 16; k++) step(1, k == 0, 0, 0, 8'(8'h10 + k));
    chk("full_done", 128'(frame_done), 128'(1));
    chk("full_ch5",  128'(chan(5)),    128'(8'h15));
    chk("full_ch15", 128'(chan(15)),   128'(8'h1F));
    chk("full_idx",  128'(ch_idx),     128'(0));
    step(0, 0, 0, 0, 8'h00);

    // Stray word in IDLE
    step(1, 0, 0, 0, 8'h55);
    chk("stray_err",   128'(frame_err), 128'(1));
    chk("stray_valid", 128'(out_valid), 128'(0));
    chk("stray_ch0",   128'(chan(0)),   128'(8'h10));

    // Short frame
    for (int k = 0; k < 5; k++) step(1, k == 0, 0, 0, 8'(8'hA0 + k));
    step(1, 1, 0, 0, 8'hB0);
    chk("short_err", 128'(frame_err), 128'(1));
    chk("short_ch0", 128'(chan(0)),   128'(8'hB0));
    chk("short_ch4", 128'(chan(4)),   128'(8'hA4));
    chk("short_idx", 128'(ch_idx),    128'(1));

    // Address mode
    step(1, 1, 1, 4'd9, 8'h3C);
    chk("addr_valid9", 128'(out_valid), 128'(16'h0200));
    chk("addr_ch9",    128'(chan(9)),   128'(8'h3C));
    step(1, 0, 1, 4'd0, 8'hC3);
    chk("addr_valid0", 128'(out_valid), 128'(16'h0001));
    chk("addr_err",    128'(frame_err), 128'(0));
    step(1, 0, 0, 0, 8'h77);
    chk("addr_abandon_err", 128'(frame_err), 128'(1));

    // Gaps after channel 7
    for (int k = 0; k < 16; k++) begin
      step(1, k == 0, 0, 0, 8'(8'h20 + k));
      if (k == 7) begin
        for (int g = 0; g < 3; g++) begin
          step(0, 0, 0, 0, 8'hFF);
          chk("gap_idx", 128'(ch_idx), 128'(8));
        end
      end
    end
    chk("gap_done", 128'(frame_done), 128'(1));

    // Reset mid-frame
    for (int k = 0; k < 7; k++) step(1, k == 0, 0, 0, 8'(8'h40 + k));
    rst_n = 1'b0;
    step(1, 0, 0, 0, 8'h99);
    rst_n = 1'b1;
    chk("rst_mid_data", 128'(out_data), 128'(0));
    chk("rst_mid_idx",  128'(ch_idx),   128'(0));
    step(1, 0, 0, 0, 8'h47);
    chk("rst_mid_err", 128'(frame_err), 128'(1));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic am, v, fs;
      rst_n = ($urandom_range(0, 99) != 0);
      am = ($urandom_range(0, 7) == 0);
      v  = am ? 1'b1 : ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 11) == 0);
      step(v, fs, am, 4'($urandom), 8'($urandom));
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux_16ch.md
# tdm_demux_16ch

Registered 1-to-16 time-division demultiplexer, the receive-side counterpart of the 16:1 channel multiplexers in the multiplexer library. It accepts one word per valid cycle from a single shared bus and routes it into one of 16 per-channel holding registers. In frame mode a sequencer assigns channels 0..15 in order after a frame marker. In address mode an explicit 4-bit select chooses the channel. Downstream per-channel logic consumes `out_data` slices, qualified by per-channel strobes.

## Interface
- `DATA_W`, default 8: width of each channel word (1..32).
- `clk  input  1`: rising-edge clock; the only clock.
- `rst_n  input  1`: synchronous, active-low reset.
- `in_valid  input  1`: a word is presented on `in_data` this cycle.
- `in_data  input  DATA_W`: input word.
- `frame_start  input  1`: marks the current valid word as channel 0; ignored unless `in_valid`=1.
- `addr_mode  input  1`: 1 = route by `in_sel`; 0 = frame sequencing.
- `in_sel  input  4`: target channel in address mode; bit 0 is LSB, equivalent to s0.
- `out_data  output  16*DATA_W`: channel k lives at bits [k*DATA_W +: DATA_W].
- `out_valid  output  16`: one-cycle strobe per channel, set when that channel's register is written.
- `ch_idx  output  4`: next channel the sequencer expects.
- `frame_done  output  1`: one-cycle pulse when channel 15 of a frame is written.
- `frame_err  output  1`: one-cycle pulse on a framing error.

## Operation
- FSM states:
  - IDLE: waiting for a frame.
  - RUN: mid-frame; `ch_idx` holds the next channel.
- Word acceptance: every cycle with `in_valid`=1 is an accepted word. There is no backpressure.
- Frame mode (`addr_mode`=0):
  - IDLE, `frame_start`=1: write channel 0, set `ch_idx`=1, go to RUN.
  - IDLE, `frame_start`=0: drop the word, pulse `frame_err`, stay in IDLE.
  - RUN, `frame_start`=0: write channel `ch_idx`, then increment `ch_idx`.
  - RUN, writing channel 15: pulse `frame_done`, set `ch_idx` to 0, go to IDLE. `ch_idx` wraps 15 to 0 and never exceeds 15.
  - RUN, `frame_start`=1 (short frame): pulse `frame_err`, write channel 0, set `ch_idx`=1, stay in RUN. The partial frame's registers keep their values and no `frame_done` is issued for it.
- Address mode (`addr_mode`=1):
  - Each valid word writes channel `in_sel`.
  - FSM is forced to IDLE and `ch_idx` to 0.
  - `frame_start` is ignored; `frame_done` and `frame_err` are never asserted.
- Mode switch mid-frame (0→1): the frame is abandoned silently and the next frame must begin with `frame_start`.
- Channels not written retain their previous value.
- Exactly one `out_valid` bit can be set in any cycle.
- Cycles with `in_valid`=0 change nothing except clearing the strobes.

## Timing
- All outputs are registered.
- Latency: a word accepted at edge N appears in `out_data` after edge N, with its `out_valid` bit high for exactly that one cycle.
- `frame_done` coincides with `out_valid[15]`; `frame_err` is asserted in the same cycle the offending word would have been written.
- Throughput: one word per clock, back-to-back. A frame with `frame_start` asserted on consecutive words restarts each time.
- Reset, at any point including mid-frame:
  - `out_data`=0, `out_valid`=0, `ch_idx`=0, `frame_done`=0, `frame_err`=0, FSM in IDLE.
  - A word presented in the reset cycle is discarded.
- Values present at reset release: all outputs 0. The first word can be accepted on the first edge with `rst_n`=1.

## Test plan
- Full frame:
  - Stimulus: `in_valid`=1 for 16 back-to-back cycles, `frame_start` on the first, data 0x10..0x1F, `DATA_W`=8.
  - Required: channel k = 0x10+k; `out_valid` walks bit 0→15 one cycle after each word; `frame_done` with `out_valid[15]`; `ch_idx` returns to 0; FSM in IDLE.
- Short frame:
  - Stimulus: 5 words 0xA0..0xA4, then `frame_start` with 0xB0.
  - Required: `frame_err` pulses once; channel 0 = 0xB0; channels 1..4 still 0xA1..0xA4; `ch_idx`=1; no `frame_done`.
- Stray word:
  - Stimulus: in IDLE, `in_valid`=1, `frame_start`=0, data 0x55.
  - Required: `frame_err` pulse; `out_data` unchanged; `out_valid`=0.
- Address mode:
  - Stimulus: `addr_mode`=1; write 0x3C to `in_sel`=9, then 0xC3 to `in_sel`=0, with `frame_start` toggling.
  - Required: channel 9 = 0x3C, `out_valid`=0x0200; then channel 0 = 0xC3, `out_valid`=0x0001; no `frame_done`/`frame_err`.
- Gaps:
  - Stimulus: full frame with `in_valid` deasserted for 3 cycles after channel 7.
  - Required: `ch_idx` holds 8 through the gap; frame completes correctly with `frame_done`.
- Reset mid-frame:
  - Stimulus: `rst_n`=0 for one cycle after channel 6 is written.
  - Required: all outputs 0 the next cycle; a following word without `frame_start` gives `frame_err`.
